ycr_pipe_div: RTL and testbench

Multi-cycle 33-bit signed/unsigned integer divider for the RV32M DIV/DIVU/REM/REMU path. It is the inverse-operation companion to the pipeline multiplier and sits beside it in the execute stage, using the same valid/ready/done handshake. Bit[32] of each operand is the sign flag, set by the caller for signed ops and clear for unsigned ops. The block uses restoring division on magnitudes, then applies a sign-correction stage.

---
 rtl/ycr_div_pkg.sv | 25 ++
 rtl/ycr_div_step.sv | 31 +++
 rtl/ycr_pipe_div.sv | 204 ++++++++++++++++++++
 tb/tb_ycr_pipe_div.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/ycr_div_pkg.sv
// Shared definitions for the ycr_pipe_div integer divider: FSM state
// encoding, the divide-by-zero quotient constant and a magnitude helper.
package ycr_div_pkg;

    typedef enum logic [1:0] {
        YCR_DIV_IDLE = 2'b00,
        YCR_DIV_CALC = 2'b01,
        YCR_DIV_CORR = 2'b10,
        YCR_DIV_EXIT = 2'b11
    } type_ycr_div_fsm_e;

    localparam logic [31:0] YCR_DIV_DBZ_QUO = 32'hFFFF_FFFF;

    // Magnitude of a 32-bit operand whose sign flag is carried separately.
    function automatic logic [31:0] ycr_div_mag(input logic [31:0] val, input logic neg);
        logic [31:0] res;
        if (neg) begin
            res = ~val + 32'd1;
        end else begin
            res = val;
        end
        return res;
    endfunction

endpackage

// File: rtl/ycr_div_step.sv
// One restoring-division step: shift {rem,quo} left by one, try to subtract
// the divisor from the partial remainder and record the outcome in the
// quotient LSB. Purely combinational; chained to resolve several bits/cycle.
module ycr_div_step
    import ycr_div_pkg::*;
(
    input  logic [32:0] rem_i,
    input  logic [31:0] quo_i,
    input  logic [31:0] dvsr_i,
    output logic [32:0] rem_o,
    output logic [31:0] quo_o
);

    logic [33:0] rem_sh_s;
    logic [34:0] trial_s;

    // Trial subtraction; the partial remainder stays below 2*divisor, so a
    // non-negative trial always fits back into the 33-bit remainder.
    always_comb begin
        rem_sh_s = {rem_i, quo_i[31]};
        trial_s  = {1'b0, rem_sh_s} - {3'b000, dvsr_i};
        if (trial_s[34:33] == 2'b00) begin
            rem_o = trial_s[32:0];
            quo_o = {quo_i[30:0], 1'b1};
        end else begin
            rem_o = rem_sh_s[32:0];
            quo_o = {quo_i[30:0], 1'b0};
        end
    end

endmodule

// File: rtl/ycr_pipe_div.sv
// ycr_pipe_div: multi-cycle 33-bit signed/unsigned divider for RV32M
// DIV/DIVU/REM/REMU. Restoring division on magnitudes followed by a single
// sign-correction cycle, with a valid/ready/done handshake.
// Optional build macro YCR_DIV_EARLY_EXIT_EN: when |dividend| < |divisor|
// the iterative phase is skipped (same results, 2-cycle latency).
module ycr_pipe_div
    import ycr_div_pkg::*;
#(
    parameter int STEPS_PER_CYC = 1,
    parameter int CNT_W         = 5
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        data_valid,
    input  logic [32:0] Din1,
    input  logic [32:0] Din2,
    output logic [31:0] quo_o,
    output logic [31:0] rem_o,
    output logic        div_rdy_o,
    input  logic        data_done
);

    localparam int              NCYC     = 32 / STEPS_PER_CYC;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NCYC - 1);

    type_ycr_div_fsm_e state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [32:0]       rem_q, rem_d;
    logic [31:0]       quo_q, quo_d;
    logic [31:0]       dvsr_q, dvsr_d;
    logic              neg_quo_q, neg_quo_d;
    logic              neg_rem_q, neg_rem_d;
    logic              dbz_q, dbz_d;
    logic              rdy_q, rdy_d;
    logic              div_rdy_q, div_rdy_d;
    logic [31:0]       quo_out_q, quo_out_d;
    logic [31:0]       rem_out_q, rem_out_d;

    logic [31:0]       dvd_mag_s;
    logic [31:0]       dvs_mag_s;
    logic [32:0]       step_rem_s;
    logic [31:0]       step_quo_s;

    assign dvd_mag_s = ycr_div_mag(Din1[31:0], Din1[32]);
    assign dvs_mag_s = ycr_div_mag(Din2[31:0], Din2[32]);

    genvar gi;
    for (gi = 0; gi < STEPS_PER_CYC; gi++) begin : g_step
        logic [32:0] rem_in_s;
        logic [31:0] quo_in_s;
        logic [32:0] rem_out_s;
        logic [31:0] quo_out_s;

        if (gi == 0) begin : g_first
            assign rem_in_s = rem_q;
            assign quo_in_s = quo_q;
        end else begin : g_next
            assign rem_in_s = g_step[gi-1].rem_out_s;
            assign quo_in_s = g_step[gi-1].quo_out_s;
        end

        ycr_div_step u_step (
            .rem_i  (rem_in_s),
            .quo_i  (quo_in_s),
            .dvsr_i (dvsr_q),
            .rem_o  (rem_out_s),
            .quo_o  (quo_out_s)
        );
    end

    assign step_rem_s = g_step[STEPS_PER_CYC-1].rem_out_s;
    assign step_quo_s = g_step[STEPS_PER_CYC-1].quo_out_s;

    // Next-state and datapath update for the IDLE/CALC/CORR/EXIT sequence.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        dvsr_d    = dvsr_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        dbz_d     = dbz_q;
        rdy_d     = 1'b0;

        case (state_q)
            YCR_DIV_IDLE: begin
                if (data_valid) begin
                    neg_quo_d = Din1[32] ^ Din2[32];
                    neg_rem_d = Din1[32];
                    dvsr_d    = dvs_mag_s;
                    cnt_d     = {CNT_W{1'b0}};
                    if (dvs_mag_s == 32'd0) begin
                        // RISC-V divide-by-zero: fixed quotient, raw dividend as remainder.
                        dbz_d   = 1'b1;
                        quo_d   = YCR_DIV_DBZ_QUO;
                        rem_d   = {1'b0, Din1[31:0]};
                        state_d = YCR_DIV_CORR;
`ifdef YCR_DIV_EARLY_EXIT_EN
                    end else if (dvd_mag_s < dvs_mag_s) begin
                        dbz_d   = 1'b0;
                        quo_d   = 32'd0;
                        rem_d   = {1'b0, dvd_mag_s};
                        state_d = YCR_DIV_CORR;
`endif
                    end else begin
                        dbz_d   = 1'b0;
                        quo_d   = dvd_mag_s;
                        rem_d   = 33'd0;
                        state_d = YCR_DIV_CALC;
                    end
                end else begin
                    state_d = YCR_DIV_IDLE;
                end
            end
            YCR_DIV_CALC: begin
                quo_d = step_quo_s;
                rem_d = step_rem_s;
                if (cnt_q == CNT_LAST) begin
                    state_d = YCR_DIV_CORR;
                end else begin
                    cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            YCR_DIV_CORR: begin
                if (!dbz_q) begin
                    if (neg_quo_q) begin
                        quo_d = ~quo_q + 32'd1;
                    end else begin
                        quo_d = quo_q;
                    end
                    if (neg_rem_q) begin
                        rem_d = {1'b0, ~rem_q[31:0] + 32'd1};
                    end else begin
                        rem_d = rem_q;
                    end
                end else begin
                    quo_d = quo_q;
                    rem_d = rem_q;
                end
                rdy_d   = 1'b1;
                state_d = YCR_DIV_EXIT;
            end
            YCR_DIV_EXIT: begin
                if (data_done) begin
                    state_d = YCR_DIV_IDLE;
                end else begin
                    state_d = YCR_DIV_EXIT;
                end
            end
            default: begin
                state_d = YCR_DIV_IDLE;
            end
        endcase
    end

    // Output staging: result registers load once per operation, ready pulses one cycle.
    always_comb begin
        div_rdy_d = rdy_q;
        if (rdy_q) begin
            quo_out_d = quo_q;
            rem_out_d = rem_q[31:0];
        end else begin
            quo_out_d = quo_out_q;
            rem_out_d = rem_out_q;
        end
    end

    // State, datapath and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= YCR_DIV_IDLE;
            cnt_q     <= {CNT_W{1'b0}};
            rem_q     <= 33'd0;
            quo_q     <= 32'd0;
            dvsr_q    <= 32'd0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            dbz_q     <= 1'b0;
            rdy_q     <= 1'b0;
            div_rdy_q <= 1'b0;
            quo_out_q <= 32'd0;
            rem_out_q <= 32'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            dvsr_q    <= dvsr_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            dbz_q     <= dbz_d;
            rdy_q     <= rdy_d;
            div_rdy_q <= div_rdy_d;
            quo_out_q <= quo_out_d;
            rem_out_q <= rem_out_d;
        end
    end

    assign quo_o     = quo_out_q;
    assign rem_o     = rem_out_q;
    assign div_rdy_o = div_rdy_q;

endmodule

// File: tb/tb_ycr_pipe_div.sv
// Self-checking bench for ycr_pipe_div: directed test-plan vectors plus
// randomized operands, checked against an arithmetic reference model.
module tb_ycr_pipe_div;

    logic        clk;
    logic        rstn;
    logic        data_valid;
    logic [32:0] Din1;
    logic [32:0] Din2;
    logic [31:0] quo_o;
    logic [31:0] rem_o;
    logic        div_rdy_o;
    logic        data_done;

    int total = 0;
    int bad   = 0;

    ycr_pipe_div dut (
        .clk        (clk),
        .rstn       (rstn),
        .data_valid (data_valid),
        .Din1       (Din1),
        .Din2       (Din2),
        .quo_o      (quo_o),
        .rem_o      (rem_o),
        .div_rdy_o  (div_rdy_o),
        .data_done  (data_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: signed value from sign flag + magnitude, truncating division.
    function automatic void model(input logic [32:0] a, input logic [32:0] b,
                                  output logic [31:0] q, output logic [31:0] r,
                                  output int lat);
        longint two32;
        longint am, bm, av, bv, qq, rr;
        two32 = 64'sh1_0000_0000;
        am = {32'd0, a[31:0]};
        bm = {32'd0, b[31:0]};
        if (a[32]) am = (two32 - am) % two32;
        if (b[32]) bm = (two32 - bm) % two32;
        if (bm == 0) begin
            q   = 32'hFFFF_FFFF;
            r   = a[31:0];
            lat = 2;
        end else begin
            av  = a[32] ? -am : am;
            bv  = b[32] ? -bm : bm;
            qq  = av / bv;
            rr  = av % bv;
            q   = qq[31:0];
            r   = rr[31:0];
            lat = 34;
`ifdef YCR_DIV_EARLY_EXIT_EN
            if (am < bm) lat = 2;
`endif
        end
    endfunction

    // Issue one command from IDLE, check result/latency/pulse, then release.
    // hold=0 asserts data_done in the same cycle as div_rdy_o.
    task automatic do_op(input logic [32:0] a, input logic [32:0] b, input int hold,
                         input bit lit, input logic [31:0] lq, input logic [31:0] lr,
                         input int llat);
        logic [31:0] eq, er;
        int          elat;
        int          lat;
        model(a, b, eq, er, elat);
        if (lit) begin
            check("model_pin_quo", eq, lq);
            check("model_pin_rem", er, lr);
            check("model_pin_lat", 32'(elat), 32'(llat));
        end
        data_valid = 1'b1;
        Din1 = a;
        Din2 = b;
        @(posedge clk); #1;
        data_valid = 1'b0;
        Din1 = 33'($urandom);
        Din2 = 33'($urandom);
        lat = 0;
        while (div_rdy_o !== 1'b1 && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        check("latency", 32'(lat), 32'(elat));
        check("quo", quo_o, eq);
        check("rem", rem_o, er);
        if (hold == 0) data_done = 1'b1;
        @(posedge clk); #1;
        data_done = 1'b0;
        check("rdy_pulse", {31'd0, div_rdy_o}, 32'd0);
        if (hold > 0) begin
            for (int i = 0; i < hold; i++) begin
                data_valid = 1'b1;
                Din1 = {1'b0, 32'd9};
                Din2 = {1'b0, 32'd3};
                @(posedge clk); #1;
                check("hold_quo", quo_o, eq);
                check("hold_rem", rem_o, er);
                check("hold_rdy", {31'd0, div_rdy_o}, 32'd0);
            end
            data_valid = 1'b0;
            data_done = 1'b1;
            @(posedge clk); #1;
            data_done = 1'b0;
        end
    endtask

    initial begin
        logic [31:0] av, bv;
        logic        sgn;
        int          kind;
        rstn = 1'b0;
        data_valid = 1'b0;
        data_done = 1'b0;
        Din1 = 33'd0;
        Din2 = 33'd0;
        #1;
        check("reset_quo", quo_o, 32'd0);
        check("reset_rem", rem_o, 32'd0);
        check("reset_rdy", {31'd0, div_rdy_o}, 32'd0);
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
        @(posedge clk); #1;

        // Directed test-plan vectors with hand-computed expectations.
        do_op({1'b0, 32'd100}, {1'b0, 32'd7}, 1, 1'b1, 32'd14, 32'd2, 34);
        do_op({1'b1, 32'hFFFF_FFF9}, {1'b0, 32'd2}, 0, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF,
`ifdef YCR_DIV_EARLY_EXIT_EN
              34);
`else
              34);
`endif
        do_op({1'b1, 32'h8000_0000}, 33'd0, 2, 1'b1, 32'hFFFF_FFFF, 32'h8000_0000, 2);
        do_op({1'b1, 32'h8000_0000}, {1'b1, 32'hFFFF_FFFF}, 0, 1'b1, 32'h8000_0000, 32'd0, 34);
        do_op({1'b0, 32'd1234}, {1'b0, 32'd10}, 10, 1'b1, 32'd123, 32'd4, 34);
        do_op({1'b0, 32'd5}, {1'b0, 32'd5}, 0, 1'b1, 32'd1, 32'd0, 34);

        // Reset in the middle of CALC aborts and clears outputs immediately.
        data_valid = 1'b1;
        Din1 = {1'b0, 32'd77777};
        Din2 = {1'b0, 32'd3};
        @(posedge clk); #1;
        data_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1 rstn = 1'b0;
        #1;
        check("midrst_quo", quo_o, 32'd0);
        check("midrst_rem", rem_o, 32'd0);
        check("midrst_rdy", {31'd0, div_rdy_o}, 32'd0);
        @(posedge clk); #1;
        rstn = 1'b1;
        @(posedge clk); #1;
        do_op({1'b0, 32'hFFFF_FFFF}, {1'b0, 32'd16}, 1, 1'b1, 32'h0FFF_FFFF, 32'd15, 34);

        // Randomized operands, signed and unsigned, with corner-leaning divisors.
        for (int n = 0; n < 60; n++) begin
            av   = $urandom;
            bv   = $urandom;
            sgn  = 1'($urandom_range(0, 1));
            kind = $urandom_range(0, 9);
            if (kind == 0) bv = 32'd0;
            else if (kind == 1) bv = 32'($urandom_range(1, 15));
            else if (kind == 2) av = 32'($urandom_range(0, 100));
            else if (kind == 3) bv = 32'hFFFF_FFFF;
            if (sgn) do_op({av[31], av}, {bv[31], bv}, $urandom_range(0, 3), 1'b0, 32'd0, 32'd0, 0);
            else     do_op({1'b0, av}, {1'b0, bv}, $urandom_range(0, 3), 1'b0, 32'd0, 32'd0, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
